cache_ctrl_nway: RTL and testbench
==================================

CACHE_CTRL_NWAY -- requirements
Module: cache_ctrl_nway

Interface
REQ-001 Parameter WAYS, default 2, number of cache ways; legal values 1 or 2.
REQ-002 Parameter WORDS, default 4, words per line; legal values are powers of 2 from 2 to 8; WW = log2(WORDS).
REQ-003 Parameter MEM_LAT, default 2, main-memory read latency in cycles from accepted request to data; legal values 1..4.
REQ-004 Parameter IDX_W, default 8, set index width.
REQ-005 Ports: clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-006 Ports: rd in 1 and wr in 1, CPU request strobes; index in IDX_W, set of the current request.
REQ-007 Ports: hit, valid, dirty, each in WAYS, per-way cache status from the current lookup.
REQ-008 Port: mem_stall in 1, memory cannot accept a request this cycle.
REQ-009 Ports: enable out WAYS, one-hot way select; comp, write and valid_in, each out 1, cache control.
REQ-010 Ports: use_mem_data out 1, selects memory data into the cache; word_c out WW, cache word; word_m out WW, memory word.
REQ-011 Ports: mem_rd and mem_wr, each out 1, memory request strobes.
REQ-012 Ports: done, stall, cache_hit and err, each out 1, CPU status.

Function
REQ-013 States SHALL be IDLE, WB, FILL and RETRY.
REQ-014 In IDLE with rd XOR wr: enable is all-ones, comp=1, write=wr, all in the same cycle.
REQ-015 In IDLE on a hit: done=1 and cache_hit=1 in the same cycle; the state stays IDLE.
REQ-016 On a miss, the victim is the lowest-numbered invalid way; if no way is invalid, the victim comes from the replacement policy (REQ-028).
REQ-017 On a miss: stall=1 from the next cycle until done; go to WB if the victim is valid and dirty, else go to FILL.
REQ-018 In WB, word 0..WORDS-1 is written one word per cycle: enable=victim, comp=0, mem_wr=1, word_c=word_m=counter; a word advances only when mem_stall=0.
REQ-019 In FILL, mem_rd issues words 0..WORDS-1, one per non-stalled cycle.
REQ-020 During FILL, each accepted word is written into the cache exactly MEM_LAT cycles after acceptance: write=1, comp=0, valid_in=1, use_mem_data=1, word_c=that word, enable=victim.
REQ-021 FILL exits to RETRY in the cycle after the last returned word is written.
REQ-022 In RETRY: comp=1, write=wr, enable=victim, done=1, cache_hit=0; then go to IDLE.
REQ-023 Unstalled miss latency SHALL be (dirty ? WORDS : 0) + WORDS + MEM_LAT + 1 cycles from the miss cycle to done.
REQ-024 rd and wr both high in IDLE: err=1 for one cycle, no cache or memory access, stay IDLE.
REQ-025 rd and wr are ignored outside IDLE; the CPU holds the request until done.
REQ-026 Word counters wrap at WORDS-1; mem_stall never delays already-accepted reads.

Reset
REQ-027 With rst high at a clock edge, from any state: go to IDLE; all outputs 0; word counters cleared; in-flight fill words discarded; LRU state and toggle flop cleared to 0.

Configuration
REQ-028 Macro CACHE_LRU_EN defined: one LRU bit per set (2**IDX_W bits) points to the least-recently-used way and is updated on each done for that set; it is the victim when all ways are valid.
REQ-029 Macro CACHE_LRU_EN undefined: a single victim flop toggles on every done and is the victim when all ways are valid; with WAYS=1 the victim is always way 0.

Structure
REQ-030 Package cache_ctrl_pkg SHALL hold the state enum, the legal parameter limits and the WW derivation function.
REQ-031 Sub-module fill_tracker SHALL be a MEM_LAT-deep delay line of {valid, word}, producing the cache-write strobe and word_c during FILL.

Verification (WAYS=2, WORDS=4, MEM_LAT=2)
REQ-032 Reset, then rd to index 5 with hit=01: done=cache_hit=1 in the same cycle; no mem_rd.
REQ-033 Read miss, both ways invalid: victim way 0; mem_rd on cycles 1-4 with word_m 0,1,2,3; cache writes on cycles 3-6; RETRY on cycle 7; done on cycle 7 with cache_hit=0.
REQ-034 Write miss, victim valid and dirty: 4 mem_wr cycles, then fill; done 11 cycles after the miss.
REQ-035 mem_stall high for 2 cycles during FILL word 1: word_m holds 1; each cache write still lands 2 cycles after its accept; done is delayed 2 cycles.
REQ-036 rd=wr=1: err pulses for 1 cycle; rst asserted mid-FILL: next cycle is IDLE with all outputs 0.
REQ-037 With CACHE_LRU_EN: miss, then miss to the same full set after hitting way 0: second victim is way 1; without the macro the victim alternates per done.

Source files
------------

// File: rtl/cache_ctrl_nway_pkg.sv
// rtl/cache_ctrl_nway_pkg.sv - shared state enum, parameter limits and word-index width helper
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        FILL  = 2'd2,
        RETRY = 2'd3
    } state_e;

    localparam int WAYS_MIN    = 1;
    localparam int WAYS_MAX    = 2;
    localparam int WORDS_MIN   = 2;
    localparam int WORDS_MAX   = 8;
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    function automatic int calc_ww(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// rtl/cache_ctrl_nway_if.sv - CPU, cache-status and memory signals of the cache controller
interface cache_ctrl_nway_if #(
    parameter int WAYS  = 2,
    parameter int WORDS = 4,
    parameter int IDX_W = 8
);
    import cache_ctrl_pkg::*;

    localparam int WW = calc_ww(WORDS);

    logic             rd;
    logic             wr;
    logic [IDX_W-1:0] index;
    logic [WAYS-1:0]  hit;
    logic [WAYS-1:0]  valid;
    logic [WAYS-1:0]  dirty;
    logic             mem_stall;

    logic [WAYS-1:0]  enable;
    logic             comp;
    logic             write;
    logic             valid_in;
    logic             use_mem_data;
    logic [WW-1:0]    word_c;
    logic [WW-1:0]    word_m;
    logic             mem_rd;
    logic             mem_wr;
    logic             done;
    logic             stall;
    logic             cache_hit;
    logic             err;

    modport slave (
        input  rd, wr, index, hit, valid, dirty, mem_stall,
        output enable, comp, write, valid_in, use_mem_data, word_c, word_m,
               mem_rd, mem_wr, done, stall, cache_hit, err
    );

    modport master (
        output rd, wr, index, hit, valid, dirty, mem_stall,
        input  enable, comp, write, valid_in, use_mem_data, word_c, word_m,
               mem_rd, mem_wr, done, stall, cache_hit, err
    );

endinterface

// File: rtl/cache_ctrl_nway_fill_tracker.sv
// rtl/cache_ctrl_nway_fill_tracker.sv - MEM_LAT-deep {valid, word} delay line timing fill writes
module fill_tracker #(
    parameter int MEM_LAT = 2,
    parameter int WW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [WW-1:0] push_word,
    output logic          out_valid,
    output logic [WW-1:0] out_word
);

    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [WW-1:0]      word_q [MEM_LAT];
    logic [WW-1:0]      word_d [MEM_LAT];

    always_comb begin
        vld_d[0]  = push_valid;
        word_d[0] = push_word;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            word_d[i] = word_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) word_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < MEM_LAT; i++) word_q[i] <= word_d[i];
        end
    end

    assign out_valid = vld_q[MEM_LAT-1];
    assign out_word  = word_q[MEM_LAT-1];

endmodule

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - N-way cache controller: hit, write-back, line fill and retry sequencing.
// CACHE_LRU_EN selects a per-set LRU bit as the full-set victim; otherwise a toggle flop is used.
module cache_ctrl_nway
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    parameter int IDX_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    cache_ctrl_nway_if.slave bus
);

    localparam int            WW   = calc_ww(WORDS);
    localparam logic [WW-1:0] LAST = WW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic [WAYS-1:0] victim_q, victim_d;
    logic            issued_q, issued_d;

`ifdef CACHE_LRU_EN
    logic [2**IDX_W-1:0] lru_q, lru_d;
    logic [WAYS-1:0]     used_oh;
    logic                used_idx;
`else
    logic                toggle_q, toggle_d;
`endif

    logic            repl_bit;
    logic            vic_idx;
    logic            vic_found;
    logic [WAYS-1:0] victim_oh;
    logic            victim_dirty;
    logic            done_int;
    logic            push_valid;
    logic            trk_valid;
    logic [WW-1:0]   trk_word;

`ifdef CACHE_LRU_EN
    assign repl_bit = lru_q[bus.index];
`else
    assign repl_bit = toggle_q;
`endif

    // Lowest invalid way wins; only a full set falls back to the replacement bit.
    always_comb begin
        vic_idx   = 1'b0;
        vic_found = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!bus.valid[w]) begin
                vic_idx   = 1'(w);
                vic_found = 1'b1;
            end
        end
        if (!vic_found && WAYS == 2) vic_idx = repl_bit;
        victim_oh    = WAYS'(1) << vic_idx;
        victim_dirty = |(victim_oh & bus.valid & bus.dirty);
    end

    fill_tracker #(
        .MEM_LAT (MEM_LAT),
        .WW      (WW)
    ) u_fill_tracker (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_word  (cnt_q),
        .out_valid  (trk_valid),
        .out_word   (trk_word)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        victim_d         = victim_q;
        issued_d         = issued_q;
        push_valid       = 1'b0;
        done_int         = 1'b0;
        bus.enable       = '0;
        bus.comp         = 1'b0;
        bus.write        = 1'b0;
        bus.valid_in     = 1'b0;
        bus.use_mem_data = 1'b0;
        bus.word_c       = '0;
        bus.word_m       = '0;
        bus.mem_rd       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.done         = 1'b0;
        bus.stall        = 1'b0;
        bus.cache_hit    = 1'b0;
        bus.err          = 1'b0;
`ifdef CACHE_LRU_EN
        used_oh          = '0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.rd && bus.wr) begin
                    bus.err = 1'b1;
                end else if (bus.rd || bus.wr) begin
                    bus.enable = '1;
                    bus.comp   = 1'b1;
                    bus.write  = bus.wr;
                    if (|bus.hit) begin
                        bus.done      = 1'b1;
                        bus.cache_hit = 1'b1;
                        done_int      = 1'b1;
`ifdef CACHE_LRU_EN
                        used_oh       = bus.hit;
`endif
                    end else begin
                        victim_d = victim_oh;
                        cnt_d    = '0;
                        issued_d = 1'b0;
                        state_d  = victim_dirty ? WB : FILL;
                    end
                end
            end
            WB: begin
                bus.stall  = 1'b1;
                bus.enable = victim_q;
                bus.mem_wr = 1'b1;
                bus.word_c = cnt_q;
                bus.word_m = cnt_q;
                if (!bus.mem_stall) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = FILL;
                end
            end
            FILL: begin
                bus.stall = 1'b1;
                if (!issued_q) begin
                    bus.mem_rd = 1'b1;
                    bus.word_m = cnt_q;
                    if (!bus.mem_stall) begin
                        push_valid = 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == LAST) issued_d = 1'b1;
                    end
                end
                // Returned words arrive in issue order, so the last word closes the fill.
                if (trk_valid) begin
                    bus.write        = 1'b1;
                    bus.valid_in     = 1'b1;
                    bus.use_mem_data = 1'b1;
                    bus.word_c       = trk_word;
                    bus.enable       = victim_q;
                    if (trk_word == LAST) state_d = RETRY;
                end
            end
            RETRY: begin
                bus.comp   = 1'b1;
                bus.write  = bus.wr;
                bus.enable = victim_q;
                bus.done   = 1'b1;
                done_int   = 1'b1;
`ifdef CACHE_LRU_EN
                used_oh    = victim_q;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CACHE_LRU_EN
    always_comb begin
        used_idx = (WAYS > 1) && used_oh[WAYS-1];
        lru_d    = lru_q;
        if (done_int) lru_d[bus.index] = ~used_idx;
    end
`else
    always_comb begin
        toggle_d = toggle_q;
        if (done_int) toggle_d = ~toggle_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            victim_q <= '0;
            issued_q <= 1'b0;
`ifdef CACHE_LRU_EN
            lru_q    <= '0;
`else
            toggle_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            issued_q <= issued_d;
`ifdef CACHE_LRU_EN
            lru_q    <= lru_d;
`else
            toggle_q <= toggle_d;
`endif
        end
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - scoreboard bench for cache_ctrl_nway with a set/way reference model
module tb_cache_ctrl_nway;
    import cache_ctrl_pkg::*;

    localparam int WAYS    = 2;
    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int IDX_W   = 8;
    localparam int NSETS   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_nway_if #(.WAYS(WAYS), .WORDS(WORDS), .IDX_W(IDX_W)) bus ();

    cache_ctrl_nway #(
        .WAYS    (WAYS),
        .WORDS   (WORDS),
        .MEM_LAT (MEM_LAT),
        .IDX_W   (IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit              is_err;
        bit              is_hit;
        logic [WAYS-1:0] victim;
        bit              wr;
        int              cyc;
    } exp_t;

    typedef struct {
        int word;
        int cyc;
    } acc_t;

    exp_t sbq[$];
    acc_t accq[$];
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    int   wb_next = 0;
    int   rd_next = 0;

    bit   mv [NSETS][WAYS];
    bit   md [NSETS][WAYS];
    bit   m_lru [NSETS];
    bit   m_toggle;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int out_vec();
        return int'({bus.enable, bus.comp, bus.write, bus.valid_in, bus.use_mem_data,
                     bus.word_c, bus.word_m, bus.mem_rd, bus.mem_wr, bus.done,
                     bus.stall, bus.cache_hit, bus.err});
    endfunction

    function automatic int policy(input int set);
`ifdef CACHE_LRU_EN
        return int'(m_lru[set]);
`else
        return int'(m_toggle);
`endif
    endfunction

    task automatic rep_update(input int set, input int way);
        m_toggle   = ~m_toggle;
        m_lru[set] = (way == 0);
    endtask

    task automatic idle_inputs();
        bus.rd        = 1'b0;
        bus.wr        = 1'b0;
        bus.hit       = '0;
        bus.valid     = '0;
        bus.dirty     = '0;
        bus.mem_stall = 1'($urandom_range(0, 1));
    endtask

    task automatic do_abort();
        rst           = 1'b1;
        bus.rd        = 1'b0;
        bus.wr        = 1'b0;
        bus.mem_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs_zero", out_vec() == 0, out_vec(), 0);
        sbq.delete();
        accq.delete();
        wb_next  = 0;
        rd_next  = 0;
        m_toggle = 1'b0;
        for (int i = 0; i < NSETS; i++) m_lru[i] = 1'b0;
    endtask

    // smode: 0 no stalls, 1 random stalls, 2 stall on cycles 2 and 3 after the miss
    task automatic do_req(input bit r, input bit w, input int set, input logic [WAYS-1:0] hv,
                          input int smode, input int abort_at);
        exp_t            e;
        logic [WAYS-1:0] vv, dv;
        int              vic, lat, t, n, last, wb;
        bit              pat [128];
        bit              got;
        for (int i = 0; i < WAYS; i++) begin
            vv[i] = mv[set][i];
            dv[i] = md[set][i];
        end
        for (int i = 0; i < 128; i++) begin
            pat[i] = 1'b0;
            if (smode == 1 && i > 0 && i < 40) pat[i] = ($urandom_range(0, 3) == 0);
        end
        if (smode == 2) begin
            pat[2] = 1'b1;
            pat[3] = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.rd        = r;
        bus.wr        = w;
        bus.index     = IDX_W'(set);
        bus.hit       = hv;
        bus.valid     = vv;
        bus.dirty     = dv;
        bus.mem_stall = 1'b0;
        e.is_err = 1'b0;
        e.is_hit = 1'b0;
        e.victim = '0;
        e.wr     = w;
        e.cyc    = cyc;
        if (r && w) begin
            e.is_err = 1'b1;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            idle_inputs();
            return;
        end
        if (hv != '0) begin
            e.is_hit = 1'b1;
            sbq.push_back(e);
            vic = hv[0] ? 0 : 1;
            if (w) md[set][vic] = 1'b1;
            rep_update(set, vic);
            @(posedge clk);
            #1;
            idle_inputs();
            return;
        end
        vic = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (!vv[i]) vic = i;
        if (vic < 0) vic = policy(set);
        // Each write-back or read transfer needs one unstalled cycle; data lands MEM_LAT later.
        t  = 1;
        wb = (vv[vic] && dv[vic]) ? WORDS : 0;
        while (wb > 0) begin
            if (!pat[t]) wb--;
            t++;
        end
        n    = WORDS;
        last = 0;
        while (n > 0) begin
            if (!pat[t]) begin
                n--;
                last = t;
            end
            t++;
        end
        lat      = last + MEM_LAT + 1;
        e.victim = WAYS'(1) << vic;
        e.cyc    = cyc + lat;
        sbq.push_back(e);
        got = 1'b0;
        for (t = 1; t < 200 && !got; t++) begin
            @(posedge clk);
            #1;
            if (t == abort_at) begin
                do_abort();
                return;
            end
            bus.mem_stall = (t < 128) ? pat[t] : 1'b0;
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        if (!got) check("done_timeout", 1'b0, 0, 1);
        mv[set][vic] = 1'b1;
        md[set][vic] = w;
        rep_update(set, vic);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        acc_t a;
        if (!rst) begin
            if (bus.err) begin
                if (sbq.size() == 0) check("err_unexpected", 1'b0, 1, 0);
                else begin
                    e = sbq.pop_front();
                    check("err_expected", e.is_err, 1, int'(e.is_err));
                    check("err_no_access", !bus.done && !bus.mem_rd && !bus.mem_wr
                          && bus.enable == '0 && !bus.comp, int'(bus.enable), 0);
                end
            end
            if (bus.done) begin
                if (sbq.size() == 0) check("done_unexpected", 1'b0, 1, 0);
                else begin
                    e = sbq.pop_front();
                    check("done_not_err", !e.is_err, 0, 0);
                    check("done_cycle", cyc == e.cyc, cyc, e.cyc);
                    check("cache_hit", bus.cache_hit == e.is_hit, int'(bus.cache_hit), int'(e.is_hit));
                    if (!e.is_hit) begin
                        check("retry_enable", bus.enable == e.victim, int'(bus.enable), int'(e.victim));
                        check("retry_write_comp", bus.write == e.wr && bus.comp,
                              int'({bus.write, bus.comp}), int'({e.wr, 1'b1}));
                    end
                end
            end
            if (bus.mem_rd || bus.mem_wr) begin
                check("mem_owner", sbq.size() > 0 && !sbq[0].is_hit && !sbq[0].is_err,
                      int'(sbq.size()), 1);
                check("stall_flag", bus.stall, int'(bus.stall), 1);
            end
            if (bus.mem_wr) begin
                check("wb_word", bus.word_m == wb_next && bus.word_c == wb_next,
                      int'(bus.word_m), wb_next);
                if (sbq.size() > 0)
                    check("wb_enable", bus.enable == sbq[0].victim && !bus.comp,
                          int'(bus.enable), int'(sbq[0].victim));
                if (!bus.mem_stall) wb_next = (wb_next + 1) % WORDS;
            end
            if (bus.write && bus.use_mem_data) begin
                if (accq.size() == 0) check("fill_unexpected", 1'b0, int'(bus.word_c), -1);
                else begin
                    a = accq.pop_front();
                    check("fill_word", int'(bus.word_c) == a.word, int'(bus.word_c), a.word);
                    check("fill_latency", cyc - a.cyc == MEM_LAT, cyc - a.cyc, MEM_LAT);
                    check("fill_ctrl", bus.valid_in && !bus.comp, int'({bus.valid_in, bus.comp}), 2);
                    if (sbq.size() > 0)
                        check("fill_enable", bus.enable == sbq[0].victim,
                              int'(bus.enable), int'(sbq[0].victim));
                end
            end
            if (bus.mem_rd) begin
                check("rd_word", int'(bus.word_m) == rd_next, int'(bus.word_m), rd_next);
                if (!bus.mem_stall) begin
                    accq.push_back('{int'(bus.word_m), cyc});
                    rd_next = (rd_next + 1) % WORDS;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit              r, w;
        int              set, way, k, ab;
        logic [WAYS-1:0] hv;
        bus.index = '0;
        idle_inputs();
        bus.mem_stall = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs_zero", out_vec() == 0, out_vec(), 0);

        do_req(1'b1, 1'b0, 5, 2'b01, 0, 0);
        do_req(1'b1, 1'b0, 1, 2'b00, 0, 0);
        mv[2][0] = 1'b1; mv[2][1] = 1'b1;
        md[2][0] = 1'b1; md[2][1] = 1'b1;
        do_req(1'b0, 1'b1, 2, 2'b00, 0, 0);
        do_req(1'b1, 1'b0, 3, 2'b00, 2, 0);
        do_req(1'b1, 1'b1, 4, 2'b00, 0, 0);
        do_req(1'b1, 1'b0, 4, 2'b00, 0, 4);
        mv[6][0] = 1'b1; mv[6][1] = 1'b1;
        md[6][0] = 1'b0; md[6][1] = 1'b0;
        do_req(1'b1, 1'b0, 6, 2'b01, 0, 0);
        do_req(1'b1, 1'b0, 6, 2'b00, 0, 0);
        do_req(1'b0, 1'b1, 6, 2'b00, 1, 0);

        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 15);
            if (k == 0) begin
                r = 1'b1;
                w = 1'b1;
            end else begin
                r = 1'($urandom_range(0, 1));
                w = !r;
            end
            set = $urandom_range(0, NSETS - 1);
            hv  = '0;
            if ($urandom_range(0, 1) == 1) begin
                way = $urandom_range(0, WAYS - 1);
                if (mv[set][way]) hv = WAYS'(1) << way;
            end
            ab = ($urandom_range(0, 49) == 0) ? $urandom_range(1, 6) : 0;
            do_req(r, w, set, hv, 1, ab);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", sbq.size() == 0, sbq.size(), 0);
        check("fill_queue_empty", accq.size() == 0, accq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
